pio_out_pulse: RTL
==================

// Module: pio_out_pulse
// PURPOSE
//  Parametrised Avalon-MM output PIO for board control lines (USB reset, PHY enables, LEDs).
//  Adds atomic set/clear writes and a hardware-timed pulse engine to the plain output PIO.
//  The pulse engine inverts selected output bits for a programmed number of clocks, then
//  restores them and raises a sticky done flag with an optional IRQ. Sits on the system
//  interconnect as a zero-wait-state slave; out_port drives FPGA pins directly.
// PARAMETERS
//  WIDTH          8      output bits, 1..32
//  RESET_VALUE    0      DATA register and out_port value at reset (WIDTH bits)
//  PULSE_W        16     pulse length counter width, 1..32
//  PULSE_DEFAULT  1000   PULSE_LEN reset value, in clk cycles
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      register select (word offset)
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, valid with chipselect
//  writedata   in   32     write data; bits above register width are ignored
//  readdata    out  32     read data, combinational, zero-extended
//  out_port    out  WIDTH  pin outputs = DATA ^ pulse_mask
//  irq         out  1      DONE & IRQ_EN
// BEHAVIOUR
//  Write occurs when chipselect & ~write_n. Read latency is 0; reads have no side effects.
//  Register map:
//   0 DATA       RW  data_out[WIDTH-1:0]
//   1 PULSE_LEN  RW  len[PULSE_W-1:0]; a value of 0 is treated as 1
//   2 PULSE      W   mask to pulse; R returns current pulse_mask (0 when idle)
//   3 CTRL       RW  b0 IRQ_EN (RW); b1 DONE (R, write 1 to clear); b2 BUSY (RO)
//   4 OUTSET     W   data_out |= wd; reads 0
//   5 OUTCLEAR   W   data_out &= ~wd; reads 0
//   6,7          reserved; writes ignored, reads 0
//  Reset values:
//   data_out = RESET_VALUE, len = PULSE_DEFAULT, pulse_mask = 0, cnt = 0, state IDLE,
//   IRQ_EN = 0, DONE = 0. Hence out_port = RESET_VALUE and irq = 0 immediately on reset.
//  Pulse FSM:
//   IDLE -> ACTIVE on a write to PULSE with wd[WIDTH-1:0] != 0.
//    Loads pulse_mask = wd and cnt = max(len,1).
//   ACTIVE: cnt decrements every clock.
//    When cnt == 1: next state IDLE, pulse_mask <= 0, DONE <= 1.
//   out_port shows the inverted bits from the cycle after the PULSE write edge, for exactly
//   max(len,1) cycles.
//   A PULSE write while ACTIVE is ignored (mask and cnt unchanged). A mask of 0 is ignored.
//  Simultaneous events:
//   - DATA/OUTSET/OUTCLEAR writes during a pulse update data_out immediately;
//     out_port = new data ^ mask.
//   - A PULSE_LEN write during a pulse affects only the next pulse.
//   - A DONE set and a W1C on the same edge: set wins.
//  Reset mid-pulse aborts the pulse; no DONE is set.
//  out_port is the XOR of two registers and carries no combinational input path.
// STRUCTURE
//  Package pio_pkg:
//   - address localparams ADDR_DATA..ADDR_OUTCLEAR
//   - CTRL bit indices CTRL_IRQ_EN=0, CTRL_DONE=1, CTRL_BUSY=2
//  Sub-module pio_pulse_timer (PULSE_W):
//   - ports clk, reset_n, start, len, busy, done_pulse
//   - holds the IDLE/ACTIVE FSM and down-counter
//  Top level holds the register file, mask register, DONE/IRQ logic and read mux.
// TESTING
//  1. Reset: reset_n=0, WIDTH=8, RESET_VALUE=8'hA5 -> out_port=A5, irq=0, read PULSE_LEN=1000.
//  2. Set/clear: write DATA=0x0F, OUTSET=0x30, OUTCLEAR=0x01 -> out_port=0x3E, read DATA=0x3E.
//  3. Pulse: DATA=0, LEN=5, PULSE=0x01 -> out_port[0]=1 for exactly 5 clks; DONE=1; BUSY=0.
//     With IRQ_EN=1, irq goes high on the same edge that sets DONE. W1C on CTRL -> irq=0.
//  4. Busy and zero cases:
//     - PULSE=0x02 while a 0x01 pulse is active -> ignored; only bit0 pulses.
//     - LEN=0 -> 1-clk pulse.
//     - mask 0 -> no pulse, no DONE.
//  5. Overlap: DATA=0x01 with pulse mask 0x01 -> out_port[0]=0 during pulse, 1 after.
//     A DATA write mid-pulse is reflected the next cycle.
//  6. Reset mid-pulse: assert reset_n at cnt=3 -> out_port=RESET_VALUE at once; after release
//     DONE=0 and BUSY=0.

Source files
------------

// File: rtl/pio_pkg.sv
// ----------------------------------------------------------------------------
// pio_pkg
//   Shared constants for the pulse-capable output PIO: register word offsets,
//   CTRL bit positions and the pulse timer state encodings.
// ----------------------------------------------------------------------------
package pio_pkg;

  // Register word offsets on the 3-bit slave address.
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_CTRL      = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  // CTRL register bit positions.
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_BUSY   = 2;

  // Pulse timer states.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/pio_pulse_timer.sv
// ----------------------------------------------------------------------------
// pio_pulse_timer
//   IDLE/ACTIVE pulse length timer. A start in IDLE loads the down-counter
//   with max(len,1); the timer stays ACTIVE for exactly that many cycles and
//   flags the final cycle on done_pulse.
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   begin a pulse (ignored while ACTIVE)
//   len         in   pulse length in cycles, 0 treated as 1
//   busy        out  1 while ACTIVE; this is the FSM state itself
//   done_pulse  out  1 during the last ACTIVE cycle
// ----------------------------------------------------------------------------
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PULSE_W-1:0] len,
  output logic               busy,
  output logic               done_pulse
);

  logic [0:0]         r_state;
  logic [PULSE_W-1:0] r_cnt;
  logic [PULSE_W-1:0] w_load_val;
  logic               w_last;

  // A programmed length of zero still produces a one-cycle pulse.
  assign w_load_val = (len == '0) ? PULSE_W'(1) : len;
  assign w_last     = (r_cnt == PULSE_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= w_load_val;
          end
        end
        ST_ACTIVE: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - PULSE_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy       = (r_state == ST_ACTIVE);
  assign done_pulse = busy && w_last;

endmodule

// File: rtl/pio_out_pulse.sv
// ----------------------------------------------------------------------------
// pio_out_pulse
//   Avalon-MM zero-wait-state output PIO with atomic set/clear and a timed
//   pulse engine that inverts selected output bits for a programmed number
//   of clocks, then raises a sticky DONE flag (optionally an IRQ).
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   address        register word offset (0 DATA, 1 PULSE_LEN, 2 PULSE,
//                  3 CTRL, 4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect     slave select
//   write_n        active-low write strobe; write = chipselect & ~write_n
//   writedata      write data, upper unused bits ignored
//   readdata       combinational, zero-extended read data
//   out_port       pins = DATA ^ pulse mask (registers only)
//   irq            DONE & IRQ_EN
// Bus handshake: every access completes in the cycle it is presented; a write
// is captured on the rising edge where chipselect=1 and write_n=0, and
// readdata reflects the addressed register in the same cycle with no side
// effects.
// ----------------------------------------------------------------------------
module pio_out_pulse
  import pio_pkg::*;
#(
  parameter int          WIDTH         = 8,
  parameter logic [31:0] RESET_VALUE   = 32'h0,
  parameter int          PULSE_W       = 16,
  parameter logic [31:0] PULSE_DEFAULT = 32'd1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0]   r_data;
  logic [PULSE_W-1:0] r_len;
  logic [WIDTH-1:0]   r_mask;
  logic               r_irq_en;
  logic               r_done;

  logic               w_wr;
  logic               w_wr_data;
  logic               w_wr_len;
  logic               w_wr_pulse;
  logic               w_wr_ctrl;
  logic               w_wr_set;
  logic               w_wr_clr;
  logic [WIDTH-1:0]   w_wd;
  logic               w_start;
  logic               w_busy;
  logic               w_done_pulse;
  logic               w_unused_wd;

  assign w_wr       = chipselect & ~write_n;
  assign w_wr_data  = w_wr && (address == ADDR_DATA);
  assign w_wr_len   = w_wr && (address == ADDR_PULSE_LEN);
  assign w_wr_pulse = w_wr && (address == ADDR_PULSE);
  assign w_wr_ctrl  = w_wr && (address == ADDR_CTRL);
  assign w_wr_set   = w_wr && (address == ADDR_OUTSET);
  assign w_wr_clr   = w_wr && (address == ADDR_OUTCLEAR);
  assign w_wd       = writedata[WIDTH-1:0];

  // Bits of writedata above the register widths are deliberately dropped.
  assign w_unused_wd = ^writedata;

  // A zero mask or a request while a pulse runs does not start anything.
  assign w_start = w_wr_pulse && (w_wd != '0) && !w_busy;

  pio_pulse_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (w_start),
    .len        (r_len),
    .busy       (w_busy),
    .done_pulse (w_done_pulse)
  );

  // Output data register with atomic set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE[WIDTH-1:0];
    end else if (w_wr_data) begin
      r_data <= w_wd;
    end else if (w_wr_set) begin
      r_data <= r_data | w_wd;
    end else if (w_wr_clr) begin
      r_data <= r_data & ~w_wd;
    end
  end

  // Pulse length; a write during a pulse only affects the next pulse because
  // the timer samples it solely on start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= PULSE_DEFAULT[PULSE_W-1:0];
    end else if (w_wr_len) begin
      r_len <= writedata[PULSE_W-1:0];
    end
  end

  // Pulse mask: loaded on start, cleared on the edge that ends the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_start) begin
      r_mask <= w_wd;
    end else if (w_done_pulse) begin
      r_mask <= '0;
    end
  end

  // CTRL: IRQ enable and sticky DONE. Setting DONE wins over a same-edge W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (w_done_pulse) begin
        r_done <= 1'b1;
      end else if (w_wr_ctrl && writedata[CTRL_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

  assign out_port = r_data ^ r_mask;
  assign irq      = r_done & r_irq_en;

  // Read mux, zero-extended; write-only and reserved offsets read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0]   = r_data;
      ADDR_PULSE_LEN: readdata[PULSE_W-1:0] = r_len;
      ADDR_PULSE:     readdata[WIDTH-1:0]   = r_mask;
      ADDR_CTRL: begin
        readdata[CTRL_IRQ_EN] = r_irq_en;
        readdata[CTRL_DONE]   = r_done;
        readdata[CTRL_BUSY]   = w_busy;
      end
      default:        readdata = '0;
    endcase
  end

endmodule
